// File: rtl/player_hit_detector.sv
// player_hit_detector
//   Player-side receiver of the enemy projectile interface. Each cycle the
//   projectile position is tested against the player hitbox. A hit returns a
//   one-cycle destroy pulse to the invader, takes a life and opens an
//   invulnerability window. Game over is flagged when lives run out.
//
// Ports
//   clk_4               in   game logic clock (rising edge)
//   clr_n               in   synchronous active-low reset
//   play                in   game running; low returns the block to IDLE
//   enemy_projectiles_x in   [9:0] projectile x
//   enemy_projectiles_y in   [9:0] projectile y, 0 = no projectile in flight
//   player_x            in   [9:0] player centre x
//   player_y            in   [9:0] player centre y
//   destroy             out  one-cycle pulse: invader clears its projectile
//   lives               out  [2:0] remaining lives
//   invuln              out  high during the invulnerability window
//   game_over           out  high once all lives are lost
//   hit_count           out  [7:0] hits this game, saturating at 255
module player_hit_detector #(
    parameter int START_LIVES   = 3,
    parameter int HIT_HALF_W    = 8,
    parameter int HIT_HALF_H    = 8,
    parameter int INVULN_CYCLES = 120
) (
    input  logic       clk_4,
    input  logic       clr_n,
    input  logic       play,
    input  logic [9:0] enemy_projectiles_x,
    input  logic [9:0] enemy_projectiles_y,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    output logic       destroy,
    output logic [2:0] lives,
    output logic       invuln,
    output logic       game_over,
    output logic [7:0] hit_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_HIT,
        S_INVULN,
        S_OVER
    } state_e;

    localparam logic [2:0]  START_L     = 3'(START_LIVES);
    localparam logic [10:0] HALF_W      = 11'(HIT_HALF_W);
    localparam logic [10:0] HALF_H      = 11'(HIT_HALF_H);
    localparam logic [15:0] INVULN_LOAD = 16'(INVULN_CYCLES - 1);

    state_e      state_q, state_d;
    logic        destroy_q, destroy_d;
    logic [2:0]  lives_q, lives_d;
    logic        invuln_q, invuln_d;
    logic        game_over_q, game_over_d;
    logic [7:0]  hit_count_q, hit_count_d;
    logic [15:0] timer_q, timer_d;

    // Hitbox test. Everything is widened to 11 bits so the absolute
    // difference and the upper bound cannot wrap; the lower bound clamps at 0.
    logic [10:0] ex_w, px_w, ey_w, py_w;
    logic [10:0] dx, y_lo, y_hi;
    logic        hit;

    always_comb begin
        ex_w = {1'b0, enemy_projectiles_x};
        px_w = {1'b0, player_x};
        ey_w = {1'b0, enemy_projectiles_y};
        py_w = {1'b0, player_y};
        dx   = (ex_w >= px_w) ? (ex_w - px_w) : (px_w - ex_w);
        y_lo = (py_w >= HALF_H) ? (py_w - HALF_H) : 11'd0;
        y_hi = py_w + HALF_H;
        hit  = (enemy_projectiles_y != 10'd0) && (dx <= HALF_W) &&
               (ey_w >= y_lo) && (ey_w <= y_hi);
    end

    // State register plus the registered outputs and window timer.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_4) begin
        if (!clr_n) begin
            state_q     <= S_IDLE;
            destroy_q   <= 1'b0;
            lives_q     <= START_L;
            invuln_q    <= 1'b0;
            game_over_q <= 1'b0;
            hit_count_q <= 8'd0;
            timer_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            destroy_q   <= destroy_d;
            lives_q     <= lives_d;
            invuln_q    <= invuln_d;
            game_over_q <= game_over_d;
            hit_count_q <= hit_count_d;
            timer_q     <= timer_d;
        end
    end

    // Next-state logic; play=0 overrides everything below reset.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned
        // (which would infer a latch).
        state_d = state_q;
        if (!play) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   state_d = S_ARMED;
                S_ARMED:  if (hit) state_d = S_HIT;
                S_HIT:    state_d = (lives_q == 3'd0) ? S_OVER : S_INVULN;
                S_INVULN: if (timer_q == 16'd0) state_d = S_ARMED;
                S_OVER:   state_d = S_OVER;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Output/datapath logic: next values of the registered outputs.
    always_comb begin
        destroy_d   = 1'b0;
        lives_d     = lives_q;
        invuln_d    = invuln_q;
        game_over_d = game_over_q;
        hit_count_d = hit_count_q;
        timer_d     = timer_q;
        if (!play || state_q == S_IDLE) begin
            lives_d     = START_L;
            invuln_d    = 1'b0;
            game_over_d = 1'b0;
            hit_count_d = 8'd0;
            timer_d     = 16'd0;
        end else begin
            case (state_q)
                S_ARMED: begin
                    if (hit) begin
                        destroy_d = 1'b1;
                        if (lives_q != 3'd0) lives_d = lives_q - 3'd1;
                        if (hit_count_q != 8'hFF) hit_count_d = hit_count_q + 8'd1;
                    end
                end
                S_HIT: begin
                    if (lives_q == 3'd0) begin
                        game_over_d = 1'b1;
                    end else begin
                        // Loaded with N-1 and run down to 0: N cycles in INVULN.
                        timer_d  = INVULN_LOAD;
                        invuln_d = 1'b1;
                    end
                end
                S_INVULN: begin
                    if (timer_q == 16'd0) invuln_d = 1'b0;
                    else                  timer_d  = timer_q - 16'd1;
                end
                S_OVER: begin
                    lives_d     = 3'd0;
                    game_over_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign destroy   = destroy_q;
    assign lives     = lives_q;
    assign invuln    = invuln_q;
    assign game_over = game_over_q;
    assign hit_count = hit_count_q;

endmodule
